pc_redirect_arbiter: RTL and testbench



---
 rtl/pcu_pkg.sv | 6 +
 rtl/redirect_prio_sel.sv | 41 ++++
 rtl/pc_redirect_arbiter.sv | 136 +++++++++++++
 tb/tb_pc_redirect_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// Shared types and constants for the PC-unit redirect path.
package pcu_pkg;
  typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;
  typedef enum logic [1:0] {SRC_TRAP, SRC_BR0, SRC_BR1} src_t;
  localparam int FETCH_BYTES = 8;
endpackage

// File: rtl/redirect_prio_sel.sv
// Fixed-priority redirect select: trap > br0 > br1, with a count of losing branches.
module redirect_prio_sel
  import pcu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              br0_valid,
  input  logic [ADDR_W-1:0] br0_addr,
  input  logic              br1_valid,
  input  logic [ADDR_W-1:0] br1_addr,
  output logic              win_valid,
  output logic [ADDR_W-1:0] win_addr,
  output logic [1:0]        lose_cnt
);
  src_t win_src;

  always_comb begin
    win_src  = SRC_BR1;
    lose_cnt = 2'd0;
    if (trap_valid) begin
      win_src  = SRC_TRAP;
      lose_cnt = {1'b0, br0_valid} + {1'b0, br1_valid};
    end else if (br0_valid) begin
      win_src  = SRC_BR0;
      lose_cnt = {1'b0, br1_valid};
    end
  end

  always_comb begin
    win_addr = br1_addr;
    case (win_src)
      SRC_TRAP: win_addr = trap_addr;
      SRC_BR0:  win_addr = br0_addr;
      default:  win_addr = br1_addr;
    endcase
  end

  assign win_valid = trap_valid | br0_valid | br1_valid;
endmodule

// File: rtl/pc_redirect_arbiter.sv
// Merges trap and branch redirects into one aligned jump pulse, holds it while the
// PC unit's jump buffer is full, and squashes wrong-path branches after each jump.
module pc_redirect_arbiter
  import pcu_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int SQUASH_CYCLES = 2,
  parameter int ALIGN_BITS    = $clog2(FETCH_BYTES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              br0_valid_i,
  input  logic [ADDR_W-1:0] br0_addr_i,
  input  logic              br1_valid_i,
  input  logic [ADDR_W-1:0] br1_addr_i,
  input  logic              slot_free_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic [7:0]        drop_cnt_o
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;
  localparam logic [3:0]        SQ_LOAD    = 4'(SQUASH_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] held_q, held_d;
  logic [ADDR_W-1:0] jaddr_d;
  logic              jflag_d, flush_d;
  logic [1:0]        drops;
  logic [8:0]        drop_sum;

  logic              win_valid;
  logic [ADDR_W-1:0] win_addr, win_tgt;
  logic [1:0]        lose_cnt;

  redirect_prio_sel #(.ADDR_W(ADDR_W)) u_sel (
    .trap_valid (trap_valid_i),
    .trap_addr  (trap_addr_i),
    .br0_valid  (br0_valid_i),
    .br0_addr   (br0_addr_i),
    .br1_valid  (br1_valid_i),
    .br1_addr   (br1_addr_i),
    .win_valid  (win_valid),
    .win_addr   (win_addr),
    .lose_cnt   (lose_cnt)
  );

  assign win_tgt = win_addr & ALIGN_MASK;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    jflag_d = 1'b0;
    jaddr_d = jump_addr_o;
    flush_d = 1'b0;
    drops   = {1'b0, br0_valid_i} + {1'b0, br1_valid_i};
    case (state_q)
      IDLE: begin
        drops = lose_cnt;
        if (win_valid) begin
          held_d  = win_tgt;
          flush_d = 1'b1;
          if (slot_free_i) begin
            jflag_d = 1'b1;
            jaddr_d = win_tgt;
            cnt_d   = SQ_LOAD;
            state_d = DRAIN;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // A trap landing with the free slot is captured first, so the pulse carries it.
        if (trap_valid_i) begin
          held_d  = win_tgt;
          flush_d = 1'b1;
        end
        if (slot_free_i) begin
          jflag_d = 1'b1;
          jaddr_d = held_d;
          cnt_d   = SQ_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (trap_valid_i) begin
          held_d  = win_tgt;
          flush_d = 1'b1;
          if (slot_free_i) begin
            jflag_d = 1'b1;
            jaddr_d = win_tgt;
            cnt_d   = SQ_LOAD;
          end else begin
            state_d = PEND;
          end
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_cnt_o} + {7'd0, drops};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      held_q      <= '0;
      jump_flag_o <= 1'b0;
      jump_addr_o <= '0;
      flush_o     <= 1'b0;
      drop_cnt_o  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      jump_flag_o <= jflag_d;
      jump_addr_o <= jaddr_d;
      flush_o     <= flush_d;
      drop_cnt_o  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// Directed bench for pc_redirect_arbiter: priority, hold, squash, reset and saturation.
module tb_pc_redirect_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        trap_valid_i, br0_valid_i, br1_valid_i, slot_free_i;
  logic [31:0] trap_addr_i, br0_addr_i, br1_addr_i;
  logic        jump_flag_o, flush_o, busy_o;
  logic [31:0] jump_addr_o;
  logic [7:0]  drop_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  pc_redirect_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .trap_valid_i(trap_valid_i), .trap_addr_i(trap_addr_i),
    .br0_valid_i(br0_valid_i), .br0_addr_i(br0_addr_i),
    .br1_valid_i(br1_valid_i), .br1_addr_i(br1_addr_i),
    .slot_free_i(slot_free_i),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .flush_o(flush_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_valid_i = 0; br0_valid_i = 0; br1_valid_i = 0; slot_free_i = 0;
    trap_addr_i = 0; br0_addr_i = 0; br1_addr_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (jump_flag_o !== 1'b0) begin n_bad++; $display("FAIL rst_jf got %b want 0", jump_flag_o); end
    n_cmp++; if (jump_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_ja got %h want 0", jump_addr_o); end
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL rst_flush got %b want 0", flush_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy_o); end
    n_cmp++; if (drop_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rst_drop got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_single();
    do_reset();
    br0_valid_i = 1; br0_addr_i = 32'h0000_1234; slot_free_i = 1;
    tick();
    idle_inputs(); slot_free_i = 1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL single_flush got %b want 1", flush_o); end
    n_cmp++; if (jump_flag_o !== 1'b1) begin n_bad++; $display("FAIL single_jf got %b want 1", jump_flag_o); end
    n_cmp++; if (jump_addr_o !== 32'h0000_1230) begin n_bad++; $display("FAIL single_ja got %h want 00001230", jump_addr_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy0 got %b want 1", busy_o); end
    tick();
    n_cmp++; if (jump_flag_o !== 1'b0 || flush_o !== 1'b0) begin n_bad++; $display("FAIL single_once got jf=%b fl=%b want 0 0", jump_flag_o, flush_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy1 got %b want 1", busy_o); end
    n_cmp++; if (jump_addr_o !== 32'h0000_1230) begin n_bad++; $display("FAIL single_hold got %h want 00001230", jump_addr_o); end
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_idle got %b want 0", busy_o); end
  endtask

  task automatic test_conflict();
    do_reset();
    trap_valid_i = 1; trap_addr_i = 32'h8000_0000;
    br0_valid_i = 1; br0_addr_i = 32'h100;
    br1_valid_i = 1; br1_addr_i = 32'h200;
    slot_free_i = 1;
    tick();
    idle_inputs(); slot_free_i = 1;
    n_cmp++; if (jump_flag_o !== 1'b1) begin n_bad++; $display("FAIL conf_jf got %b want 1", jump_flag_o); end
    n_cmp++; if (jump_addr_o !== 32'h8000_0000) begin n_bad++; $display("FAIL conf_ja got %h want 80000000", jump_addr_o); end
    n_cmp++; if (drop_cnt_o !== 8'd2) begin n_bad++; $display("FAIL conf_drop got %0d want 2", drop_cnt_o); end
    tick();
    n_cmp++; if (jump_flag_o !== 1'b0) begin n_bad++; $display("FAIL conf_single got %b want 0", jump_flag_o); end
  endtask

  task automatic test_block_override();
    int nj, nf;
    do_reset();
    nj = 0; nf = 0;
    br1_valid_i = 1; br1_addr_i = 32'h400; slot_free_i = 0;
    tick(); nj += int'(jump_flag_o); nf += int'(flush_o);
    br1_valid_i = 0;
    n_cmp++; if (busy_o !== 1'b1 || jump_flag_o !== 1'b0) begin n_bad++; $display("FAIL blk_pend got busy=%b jf=%b want 1 0", busy_o, jump_flag_o); end
    tick(); nj += int'(jump_flag_o); nf += int'(flush_o);
    trap_valid_i = 1; trap_addr_i = 32'h8000_0010;
    tick(); nj += int'(jump_flag_o); nf += int'(flush_o);
    trap_valid_i = 0;
    n_cmp++; if (flush_o !== 1'b1 || jump_flag_o !== 1'b0) begin n_bad++; $display("FAIL blk_trap got fl=%b jf=%b want 1 0", flush_o, jump_flag_o); end
    tick(); nj += int'(jump_flag_o); nf += int'(flush_o);
    slot_free_i = 1;
    tick(); nj += int'(jump_flag_o); nf += int'(flush_o);
    slot_free_i = 0;
    n_cmp++; if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h8000_0010) begin n_bad++; $display("FAIL blk_pulse got jf=%b ja=%h want 1 80000010", jump_flag_o, jump_addr_o); end
    tick(); nj += int'(jump_flag_o); nf += int'(flush_o);
    tick(); nj += int'(jump_flag_o); nf += int'(flush_o);
    n_cmp++; if (nj !== 1) begin n_bad++; $display("FAIL blk_njump got %0d want 1", nj); end
    n_cmp++; if (nf !== 2) begin n_bad++; $display("FAIL blk_nflush got %0d want 2", nf); end
  endtask

  task automatic test_squash();
    do_reset();
    slot_free_i = 1;
    br0_valid_i = 1; br0_addr_i = 32'h100;
    tick();
    n_cmp++; if (jump_flag_o !== 1'b1) begin n_bad++; $display("FAIL sq_first got %b want 1", jump_flag_o); end
    br0_addr_i = 32'h111;
    tick();
    n_cmp++; if (jump_flag_o !== 1'b0 || drop_cnt_o !== 8'd1) begin n_bad++; $display("FAIL sq_drop1 got jf=%b drop=%0d want 0 1", jump_flag_o, drop_cnt_o); end
    tick();
    n_cmp++; if (jump_flag_o !== 1'b0 || drop_cnt_o !== 8'd2 || busy_o !== 1'b0) begin n_bad++; $display("FAIL sq_drop2 got jf=%b drop=%0d busy=%b want 0 2 0", jump_flag_o, drop_cnt_o, busy_o); end
    br0_addr_i = 32'h300;
    tick();
    br0_valid_i = 0;
    n_cmp++; if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h300 || drop_cnt_o !== 8'd2) begin n_bad++; $display("FAIL sq_accept got jf=%b ja=%h drop=%0d want 1 300 2", jump_flag_o, jump_addr_o, drop_cnt_o); end
  endtask

  task automatic test_drain_trap();
    do_reset();
    slot_free_i = 1;
    br0_valid_i = 1; br0_addr_i = 32'h700;
    tick();
    br0_valid_i = 0;
    trap_valid_i = 1; trap_addr_i = 32'h9000_0007;
    tick();
    trap_valid_i = 0;
    n_cmp++; if (jump_flag_o !== 1'b1 || flush_o !== 1'b1 || jump_addr_o !== 32'h9000_0000) begin n_bad++; $display("FAIL drt_pulse got jf=%b fl=%b ja=%h want 1 1 90000000", jump_flag_o, flush_o, jump_addr_o); end
    tick();
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL drt_reload got busy=%b want 1", busy_o); end
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL drt_idle got busy=%b want 0", busy_o); end
  endtask

  task automatic test_reset_pend();
    int nj;
    do_reset();
    br0_valid_i = 1; br0_addr_i = 32'h500; slot_free_i = 0;
    tick();
    br0_valid_i = 0; br1_valid_i = 1; br1_addr_i = 32'h520;
    tick();
    br1_valid_i = 0;
    n_cmp++; if (busy_o !== 1'b1 || drop_cnt_o !== 8'd1) begin n_bad++; $display("FAIL rp_pend got busy=%b drop=%0d want 1 1", busy_o, drop_cnt_o); end
    #2 reset_n = 0;
    #1;
    n_cmp++; if ({jump_flag_o, flush_o, busy_o} !== 3'b000 || jump_addr_o !== 32'h0 || drop_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rp_async got jf=%b fl=%b busy=%b ja=%h drop=%0d want all 0", jump_flag_o, flush_o, busy_o, jump_addr_o, drop_cnt_o); end
    tick();
    reset_n = 1;
    slot_free_i = 1;
    nj = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); nj += int'(jump_flag_o);
    end
    n_cmp++; if (nj !== 0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL rp_nojump got jumps=%0d busy=%b want 0 0", nj, busy_o); end
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    br0_valid_i = 1; br0_addr_i = 32'h600; slot_free_i = 0;
    tick();
    br1_valid_i = 1; br1_addr_i = 32'h608;
    for (int i = 1; i <= 130; i++) begin
      tick();
      exp = (2 * i > 255) ? 255 : 2 * i;
      n_cmp++; if (drop_cnt_o !== 8'(exp)) begin n_bad++; $display("FAIL sat_step%0d got %0d want %0d", i, drop_cnt_o, exp); end
    end
    idle_inputs();
    n_cmp++; if (drop_cnt_o !== 8'd255 || busy_o !== 1'b1) begin n_bad++; $display("FAIL sat_final got drop=%0d busy=%b want 255 1", drop_cnt_o, busy_o); end
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    #3;
    test_reset();
    test_single();
    test_conflict();
    test_block_override();
    test_squash();
    test_drain_trap();
    test_reset_pend();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
